// File: rtl/serial_loader_7bit_pkg.sv
// serial_loader_7bit_pkg: shared constants and state encoding for the serial loader.
// SERIAL_LOADER_PARITY_EN adds the PARITY state.
package serial_loader_7bit_pkg;
  localparam int DATA_W_DEF = 7;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
`ifdef SERIAL_LOADER_PARITY_EN
    STOP = 2'd2,
    PARITY = 2'd3
`else
    STOP = 2'd2
`endif
  } state_t;
endpackage

// File: rtl/serial_loader_7bit_sipo.sv
// sipo_shift_reg: serial-in parallel-out register with counter-indexed bit write and clear.
module sipo_shift_reg #(
  parameter int W = 7,
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          wr,
  input  logic [CW-1:0] idx,
  input  logic          din,
  output logic [W-1:0]  q
);
  logic [W-1:0] q_q, q_d;
  always_comb begin
    q_d = q_q;
    if (clr) q_d = '0;
    else if (wr) q_d[idx] = din;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/serial_loader_7bit.sv
// serial_loader_7bit: frames a strobed serial line into a DATA_W payload with a one-cycle load pulse.
// Define SERIAL_LOADER_PARITY_EN to insert and check a parity bit before the stop bit.
module serial_loader_7bit
  import serial_loader_7bit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sin,
  input  logic              sin_valid,
  output logic [DATA_W-1:0] dout,
  output logic              load,
  output logic              busy,
  output logic              frame_err
);
  localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, load_q, load_d, ferr_q, ferr_d, sr_clr, sr_wr;
  logic [DATA_W-1:0] dout_q, dout_d, sr;
  sipo_shift_reg #(.W(DATA_W), .CW(CW)) u_sipo (
    .clock(clock), .reset(reset), .clr(sr_clr), .wr(sr_wr),
    .idx(cnt_q), .din(sin), .q(sr)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    dout_d = dout_q;
    ferr_d = ferr_q;
    load_d = 1'b0;
    sr_clr = 1'b0;
    sr_wr = 1'b0;
    if (sin_valid)
      case (state_q)
        IDLE:
          if (sin == START_BIT) begin
            state_d = DATA;
            cnt_d = '0;
            err_d = 1'b0;
            sr_clr = 1'b1;
          end
        DATA: begin
          sr_wr = 1'b1;
          cnt_d = cnt_q + 1'b1;
`ifdef SERIAL_LOADER_PARITY_EN
          if (cnt_q == CW'(DATA_W - 1)) state_d = PARITY;
`else
          if (cnt_q == CW'(DATA_W - 1)) state_d = STOP;
`endif
        end
`ifdef SERIAL_LOADER_PARITY_EN
        PARITY: begin
          if (sin != (^sr ^ PARITY_ODD)) err_d = 1'b1;
          state_d = STOP;
        end
`endif
        default: begin
          state_d = IDLE;
          if (sin == STOP_BIT && !err_q) begin
            dout_d = sr;
            load_d = 1'b1;
            ferr_d = 1'b0;
          end else ferr_d = 1'b1;
        end
      endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= 1'b0;
      dout_q <= '0;
      load_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      dout_q <= dout_d;
      load_q <= load_d;
      ferr_q <= ferr_d;
    end
  assign dout = dout_q;
  assign load = load_q;
  assign frame_err = ferr_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_serial_loader_7bit.sv
// tb_serial_loader_7bit: directed frames with hand-computed payloads for serial_loader_7bit.
module tb_serial_loader_7bit;
  logic clock = 1'b0, reset = 1'b1, sin = 1'b1, sin_valid = 1'b0;
  logic [6:0] dout;
  logic load, busy, frame_err;
  int checks = 0, passed = 0, pulses = 0;

  serial_loader_7bit dut (
    .clock(clock), .reset(reset), .sin(sin), .sin_valid(sin_valid),
    .dout(dout), .load(load), .busy(busy), .frame_err(frame_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) if (load) pulses <= pulses + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic strobe(input logic b);
    sin = b;
    sin_valid = 1'b1;
    @(negedge clock);
  endtask

  task automatic gap(input int maxgap);
    int n;
    n = maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0;
    if (n > 0) begin
      sin_valid = 1'b0;
      repeat (n) begin
        @(negedge clock);
        chk("busy_gap", busy, 1);
      end
    end
  endtask

  task automatic send_frame(input logic [6:0] d, input logic stop, input logic bad_par, input int maxgap);
    strobe(1'b0);
    gap(maxgap);
    for (int i = 0; i < 7; i++) begin
      strobe(d[i]);
      gap(maxgap);
    end
`ifdef SERIAL_LOADER_PARITY_EN
    strobe(^d ^ bad_par);
    gap(maxgap);
`endif
    strobe(stop);
  endtask

  task automatic idle(input int n);
    sin_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int p;
    repeat (2) @(negedge clock);
    chk("rst_dout", dout, 0);
    chk("rst_load", load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    reset = 1'b0;
    strobe(1'b1);
    chk("idle_line_busy", busy, 0);

    send_frame(7'h65, 1'b1, 1'b0, 0);
    chk("good_load", load, 1);
    chk("good_dout", dout, 7'h65);
    chk("good_ferr", frame_err, 0);
    idle(1);
    chk("good_load_drop", load, 0);
    idle(2);
    chk("good_pulses", pulses, 1);

    p = pulses;
    send_frame(7'h65, 1'b0, 1'b0, 0);
    chk("stoperr_load", load, 0);
    chk("stoperr_ferr", frame_err, 1);
    idle(3);
    chk("stoperr_dout", dout, 7'h65);
    chk("stoperr_pulses", pulses, p);
    chk("stoperr_hold", frame_err, 1);
    send_frame(7'h7F, 1'b1, 1'b0, 0);
    chk("clear_dout", dout, 7'h7F);
    chk("clear_ferr", frame_err, 0);
    idle(2);

`ifdef SERIAL_LOADER_PARITY_EN
    p = pulses;
    send_frame(7'h01, 1'b1, 1'b1, 0);
    chk("parerr_load", load, 0);
    chk("parerr_ferr", frame_err, 1);
    idle(2);
    chk("parerr_dout", dout, 7'h7F);
    chk("parerr_pulses", pulses, p);
`endif

    send_frame(7'h2A, 1'b1, 1'b0, 5);
    chk("gaps_load", load, 1);
    chk("gaps_dout", dout, 7'h2A);
    idle(2);

    send_frame(7'h2A, 1'b0, 1'b0, 0);
    idle(1);
    p = pulses;
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    sin_valid = 1'b0;
    chk("mid_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_load", load, 0);
    @(negedge clock);
    reset = 1'b0;
    idle(2);
    chk("mid_no_pulse", pulses, p);
    send_frame(7'h11, 1'b1, 1'b0, 0);
    chk("after_rst_load", load, 1);
    chk("after_rst_dout", dout, 7'h11);
    idle(2);

    p = pulses;
    send_frame(7'h00, 1'b1, 1'b0, 0);
    chk("b2b_first_load", load, 1);
    chk("b2b_first_dout", dout, 7'h00);
    send_frame(7'h7F, 1'b1, 1'b0, 0);
    chk("b2b_second_load", load, 1);
    chk("b2b_second_dout", dout, 7'h7F);
    idle(2);
    chk("b2b_pulses", pulses, p + 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/serial_loader_7bit.md
SERIAL_LOADER_7BIT -- requirements
Module: serial_loader_7bit

Interface
REQ-001 Parameter DATA_W, default 7, payload width; SHALL match the width of the downstream 7-bit holding register.
REQ-002 Parameter PARITY_ODD, default 0, selects parity sense: 0 = even, 1 = odd. It is used only when parity is compiled in.
REQ-003 Port clock, input, 1, the single clock; all state changes on posedge clock.
REQ-004 Port reset, input, 1, reset; asynchronous and active-high.
REQ-005 Port sin, input, 1, serial line data; sampled only when sin_valid=1.
REQ-006 Port sin_valid, input, 1, bit strobe; one serial bit per cycle in which it is high.
REQ-007 Port dout, output, DATA_W, last good payload; drives the downstream register din.
REQ-008 Port load, output, 1, single-cycle pulse marking a new dout; drives the downstream register enable.
REQ-009 Port busy, output, 1, high while a frame is in progress (any state except IDLE).
REQ-010 Port frame_err, output, 1, high if the last completed frame was rejected.

Function
REQ-011 Frame format SHALL be: start bit 0, then DATA_W data bits LSB first, then the parity bit (if compiled in), then stop bit 1.
REQ-012 FSM states SHALL be IDLE, DATA, PARITY, STOP; cycles with sin_valid=0 SHALL leave all state unchanged.
REQ-013 IDLE: sin_valid=1 with sin=0 -> DATA, bit counter cleared to 0, error latch cleared; sin_valid=1 with sin=1 -> stay in IDLE (line idle).
REQ-014 DATA: each strobe shifts sin into bit position [counter] and increments the counter; the strobe with counter=DATA_W-1 -> PARITY, or -> STOP when parity is compiled out.
REQ-015 PARITY: the sampled bit is compared with the computed parity of the data bits; on mismatch the internal error latch is set; the state always -> STOP.
REQ-016 STOP: on strobe the FSM -> IDLE; good frame = (sin=1 and error latch clear).
REQ-017 Good frame: on the same edge that samples the stop bit, dout <= the shifted payload, load <= 1, and frame_err <= 0.
REQ-018 Bad frame (stop bit 0 or parity error): dout SHALL be unchanged, load stays 0, and frame_err <= 1.
REQ-019 load SHALL be high for exactly one cycle per good frame and SHALL be low in every other cycle.
REQ-020 Latency: load and the new dout SHALL be visible in the cycle immediately after the stop-bit sampling edge.
REQ-021 frame_err SHALL hold its value until the next completed frame.
REQ-022 dout SHALL never show a partially shifted payload; the shift register is internal.
REQ-023 Back-to-back frames: a start bit strobed in the cycle right after the stop bit SHALL be accepted with no lost bits.

Reset
REQ-024 Asserting reset SHALL immediately force: state=IDLE, counter=0, shift register=0, dout=0, load=0, busy=0, frame_err=0.
REQ-025 Reset in the middle of a frame SHALL abort the frame with no load pulse; the partial payload is discarded.
REQ-026 After reset deassertion, the first strobe SHALL be interpreted in IDLE.

Configuration
REQ-027 The parity feature is controlled by macro SERIAL_LOADER_PARITY_EN.
- Defined: the PARITY state exists, the frame is DATA_W+3 bits, and parity mismatches are rejected.
- Undefined: the PARITY state and parity logic are absent, the frame is DATA_W+2 bits, and PARITY_ODD is ignored.

Structure
REQ-028 A shared package SHALL hold the state encoding constants, the default DATA_W, and the START_BIT=0 / STOP_BIT=1 constants.
REQ-029 One sub-module, sipo_shift_reg (serial-in parallel-out with counter-indexed write and clear), SHALL be instantiated.
REQ-030 The FSM, error latch, and output registers SHALL live in the top module.

Verification
REQ-031 Good frame: reset, then strobe 0, 1,0,1,0,0,1,1 (LSB first), [even parity 0], 1 -> dout=7'h65 and load high exactly 1 cycle; frame_err=0.
REQ-032 Stop error: same payload with stop bit 0 -> dout keeps its prior value, no load pulse, frame_err=1; the next good frame 7'h7F clears frame_err.
REQ-033 Parity error (macro defined): payload 7'h01 with parity bit 0 under even parity -> no load, frame_err=1.
REQ-034 Strobe gaps: the 7'h2A frame with sin_valid=0 inserted for random 0-5 cycles between bits -> dout=7'h2A; busy stays high across the gaps.
REQ-035 Mid-frame reset: assert reset after the 4th data bit -> all outputs 0 immediately; a following 7'h11 frame loads correctly.
REQ-036 Back-to-back: frames 7'h00 then 7'h7F with no idle strobe between them -> two load pulses, dout sequence 7'h00 then 7'h7F.
